instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetches one- or two-byte instructions from a byte-wide instruction memory
// and hands them to the controller.
//
// The first (opcode) byte goes to ir. If bit 7 of that byte is set, the
// instruction is long. A second byte is then read, and the target register is
// built as {ir[4:0], byte2}. A short instruction clears the target register.
//
// The program counter advances once per byte fetched and wraps modulo
// 2^ADDR_W. A jump (pc_ld) is accepted only while the unit is idle. If a jump
// and a fetch request arrive in the same idle cycle, both take effect, and the
// fetch reads from the jump target.
//
// Ports
//   clk          in   1       clock, rising edge
//   rst          in   1       asynchronous, active-high reset
//   fetch_req    in   1       fetch the next instruction (sampled in IDLE)
//   pc_ld        in   1       load pc from pc_ld_addr (honoured in IDLE)
//   pc_ld_addr   in   ADDR_W  jump target
//   mem_addr     out  ADDR_W  byte address to instruction memory (always pc)
//   mem_rd       out  1       read strobe, held until mem_ack
//   mem_rdata    in   8       read data, valid while mem_ack=1
//   mem_ack      in   1       read complete (ignored when mem_rd=0)
//   ir           out  8       opcode byte
//   tr           out  ADDR_W  target/address field of long instructions
//   is_long      out  1       ir is a two-byte instruction
//   pc           out  ADDR_W  program counter
//   instr_valid  out  1       one-cycle pulse: ir/tr/is_long are new
//   busy         out  1       high in every state except IDLE
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                 ADDR_W   = 13,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              pc_ld,
  input  logic [ADDR_W-1:0] pc_ld_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        ir,
  output logic [ADDR_W-1:0] tr,
  output logic              is_long,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD0   = 2'd1;
  localparam logic [1:0] S_RD1   = 2'd2;
  localparam logic [1:0] S_VALID = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_ir;
  logic [ADDR_W-1:0] r_tr;
  logic              r_is_long;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_tr_long;

  // The add is ADDR_W bits wide, so the carry out is dropped and pc wraps.
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  // In RD1, r_ir already holds the opcode byte that was captured in RD0.
  assign w_tr_long = ADDR_W'({r_ir[4:0], mem_rdata});

  // NOTE: every state register is written with <= so that all of them update
  // together at the edge. The asynchronous reset is in the sensitivity list,
  // so the outputs drop immediately without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_tr      <= '0;
      r_is_long <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A jump and a request in the same cycle are both accepted.
          // RD0 then sees the new pc.
          if (pc_ld)     r_pc    <= pc_ld_addr;
          if (fetch_req) r_state <= S_RD0;
        end
        S_RD0: begin
          if (mem_ack) begin
            r_ir      <= mem_rdata;
            r_pc      <= w_pc_inc;
            r_is_long <= mem_rdata[7];
            if (mem_rdata[7]) begin
              r_state <= S_RD1;
            end else begin
              r_tr    <= '0;
              r_state <= S_VALID;
            end
          end
        end
        S_RD1: begin
          if (mem_ack) begin
            r_tr    <= w_tr_long;
            r_pc    <= w_pc_inc;
            r_state <= S_VALID;
          end
        end
        default: r_state <= S_IDLE;   // S_VALID: one cycle, then back to idle
      endcase
    end
  end

  // The outputs decode directly from the state register, so reset clears them
  // in the same cycle. mem_addr is simply pc, which keeps it stable while the
  // unit waits for an acknowledge.
  assign mem_rd      = (r_state == S_RD0) || (r_state == S_RD1);
  assign mem_addr    = r_pc;
  assign instr_valid = (r_state == S_VALID);
  assign busy        = (r_state != S_IDLE);
  assign pc          = r_pc;
  assign ir          = r_ir;
  assign tr          = r_tr;
  assign is_long     = r_is_long;

endmodule
